dram_readback_sequencer: RTL and testbench

- Downstream of capture: once LogCap/dram_packer have filled DRAM, this block replays the capture.
- Issues 128-bit read requests to ddr_memory_interface and drains its return-data queue.
- Unpacks each 128-bit word into four 32-bit sample packets, delivered in order on a valid/ready stream.
- Replaces the dummy consumer; the stream feeds the host-upload path.

---
 rtl/rb_pkg.sv | 17 +
 rtl/rb_word_unpacker.sv | 85 ++++++++
 rtl/dram_readback_sequencer.sv | 159 +++++++++++++++
 tb/tb_dram_readback_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared types and widths for the DRAM readback sequencer and its word unpacker.
package rb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    FIN
  } state_e;

  localparam int ADX_W      = 27;
  localparam int WORD_W     = 128;
  localparam int SAMPLE_W   = 32;
  localparam int LANES      = 4;
  localparam int LANE_IDX_W = 2;

endpackage

// File: rtl/rb_word_unpacker.sv
// 128-bit to 32-bit serializer: one holding word, a lane pointer and the running
// sample index, with truncation of the final partial word.
module rb_word_unpacker
  import rb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WORD_W-1:0]     load_data,
  input  logic [31:0]           count,
  input  logic                  sample_ready,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic [31:0]           sample_index,
  output logic                  empty,
  output logic                  emptying,
  output logic                  final_accept
);

  logic [WORD_W-1:0]     data_q, data_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic                  full_q, full_d;
  logic [31:0]           index_q, index_d;
  logic                  fire;
  logic                  last;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    data_d       = data_q;
    lane_d       = lane_q;
    full_d       = full_q;
    index_d      = index_q;

    sample_valid = full_q & ~clear;
    fire         = sample_valid & sample_ready;
    last         = (index_q == count - 32'd1);
    emptying     = fire & ((lane_q == LANE_IDX_W'(LANES - 1)) | last);
    final_accept = fire & last;
    empty        = ~full_q;
    sample_out   = data_q[lane_q*SAMPLE_W +: SAMPLE_W];
    sample_index = index_q;

    // The index parks on the final sample so it reads count-1 after completion.
    if (init) begin
      index_d = '0;
    end else if (fire && !last) begin
      index_d = index_q + 32'd1;
    end

    // A load in the same cycle as emptying is the zero-bubble refill path.
    if (clear) begin
      full_d = 1'b0;
      lane_d = '0;
    end else if (load) begin
      data_d = load_data;
      full_d = 1'b1;
      lane_d = '0;
    end else if (emptying) begin
      full_d = 1'b0;
      lane_d = '0;
    end else if (fire) begin
      lane_d = lane_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the holding word is reset too, so sample_out reads 0 out of reset.
      data_q  <= '0;
      lane_q  <= '0;
      full_q  <= 1'b0;
      index_q <= '0;
    end else begin
      data_q  <= data_d;
      lane_q  <= lane_d;
      full_q  <= full_d;
      index_q <= index_d;
    end
  end

endmodule

// File: rtl/dram_readback_sequencer.sv
// Replays a DRAM capture: issues word reads with bounded outstanding count, drains
// the return queue and streams the unpacked 32-bit samples downstream.
module dram_readback_sequencer #(
  parameter int ADX_W           = 27,
  parameter int ADX_STEP        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [ADX_W-1:0] base_adx,
  input  logic [31:0]      sample_count,
  output logic             read_req,
  output logic [ADX_W-1:0] rd_adx,
  input  logic             read_allowed,
  input  logic             has_return_data,
  output logic             get_return_data,
  input  logic [127:0]     return_data,
  input  logic [ADX_W-1:0] return_adx,
  output logic [31:0]      sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [31:0]      sample_index,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             adx_error
);
  import rb_pkg::*;

  localparam int CNT_W = 33;

  state_e           state_q, state_d;
  logic [ADX_W-1:0] base_q, base_d;
  logic [31:0]      count_q, count_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] returned_q, returned_d;
  logic [3:0]       outst_q, outst_d;
  logic             aborted_q, aborted_d;
  logic             adx_err_q, adx_err_d;

  logic             run, kill, init, load;
  logic             hold_empty, hold_emptying, final_accept;
  logic [ADX_W-1:0] exp_adx;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    words_d    = words_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_q;
    aborted_d  = aborted_q;
    adx_err_d  = adx_err_q;
    init       = 1'b0;

    run      = (state_q == RUN);
    kill     = run & abort;
    read_req = run & ~abort & (issued_q < words_q) &
               (outst_q < 4'(MAX_OUTSTANDING)) & read_allowed;
    rd_adx   = base_q + ADX_W'(issued_q) * ADX_W'(ADX_STEP);
    exp_adx  = base_q + ADX_W'(returned_q) * ADX_W'(ADX_STEP);

    // During abort and FLUSH the popped word is discarded instead of loaded.
    get_return_data = has_return_data &
                      ((state_q == FLUSH) | kill | (run & (hold_empty | hold_emptying)));
    load            = get_return_data & run & ~abort;

    if (read_req) issued_d = issued_q + 1'b1;
    if (get_return_data) begin
      returned_d = returned_q + 1'b1;
      if (return_adx != exp_adx) adx_err_d = 1'b1;
    end
    case ({read_req, get_return_data})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          init       = 1'b1;
          base_d     = base_adx;
          count_d    = sample_count;
          words_d    = ({1'b0, sample_count} + 33'd3) >> 2;
          issued_d   = '0;
          returned_d = '0;
          outst_d    = '0;
          aborted_d  = 1'b0;
          adx_err_d  = 1'b0;
          state_d    = (sample_count == 32'd0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort)             state_d = FLUSH;
        else if (final_accept) state_d = FIN;
      end
      FLUSH: begin
        if (outst_q == 4'd0) begin
          state_d   = FIN;
          aborted_d = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    aborted   = aborted_q;
    adx_error = adx_err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      words_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
      aborted_q  <= 1'b0;
      adx_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      words_q    <= words_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
      aborted_q  <= aborted_d;
      adx_err_q  <= adx_err_d;
    end
  end

  rb_word_unpacker u_unpacker (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .clear        (kill),
    .load         (load),
    .load_data    (return_data),
    .count        (count_q),
    .sample_ready (sample_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_index (sample_index),
    .empty        (hold_empty),
    .emptying     (hold_emptying),
    .final_accept (final_accept)
  );

endmodule

// File: tb/tb_dram_readback_sequencer.sv
// Directed bench for dram_readback_sequencer with a queue-based DRAM return model.
module tb_dram_readback_sequencer;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [26:0]  base_adx;
  logic [31:0]  sample_count;
  logic         read_req, read_allowed, has_return_data, get_return_data;
  logic [26:0]  rd_adx, return_adx;
  logic [127:0] return_data;
  logic [31:0]  sample_out, sample_index;
  logic         sample_valid, sample_ready;
  logic         busy, done, aborted, adx_error;

  always #5 clk = ~clk;

  dram_readback_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_adx(base_adx), .sample_count(sample_count),
    .read_req(read_req), .rd_adx(rd_adx), .read_allowed(read_allowed),
    .has_return_data(has_return_data), .get_return_data(get_return_data),
    .return_data(return_data), .return_adx(return_adx),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_index(sample_index), .busy(busy), .done(done),
    .aborted(aborted), .adx_error(adx_error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_val(input logic [26:0] adx, input int k);
    logic [1:0] kk;
    kk = k[1:0];
    return {adx, kk, 3'b101};
  endfunction

  function automatic logic [127:0] word_val(input logic [26:0] adx);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[32*k +: 32] = lane_val(adx, k);
    return w;
  endfunction

  typedef struct {
    logic [26:0] adx;
    int          t;
  } rd_t;
  rd_t q[$];

  int  cycle = 0;
  int  latency = 0;
  int  allow_limit = 1 << 30;
  int  issue_total = 0;
  bit  corrupt = 1'b0;
  bit  ready_toggle = 1'b0;

  logic [26:0] run_base = '0;
  logic [26:0] adx_log[$];
  int  hs_count, n_issued, n_popped, max_inflight, done_count, done_cycle, last_hs_cycle;
  int  start_cycle;
  bit  prev_stall = 1'b0;
  logic [31:0] prev_out, prev_idx;
  bit  cap_req, cap_pop;
  logic [26:0] cap_adx;

  // Monitor at the falling edge, then update the memory model just after the rising edge.
  always begin : mon_mem
    logic [26:0] e;
    @(negedge clk);
    cap_req = 1'b0;
    cap_pop = 1'b0;
    if (!reset) begin
      if (read_req) begin
        e = run_base + 27'(n_issued) * 27'd8;
        check("rd_adx", rd_adx, e);
        adx_log.push_back(rd_adx);
        n_issued++;
        cap_req = 1'b1;
        cap_adx = rd_adx;
      end
      if (get_return_data) begin
        n_popped++;
        cap_pop = 1'b1;
      end
      if (n_issued - n_popped > max_inflight) max_inflight = n_issued - n_popped;
      if (prev_stall && sample_valid) check("stall_hold", {sample_index, sample_out}, {prev_idx, prev_out});
      if (sample_valid && sample_ready) begin
        e = run_base + 27'(hs_count / 4) * 27'd8;
        check("sample", sample_out, lane_val(e, hs_count % 4));
        check("index", sample_index, hs_count);
        hs_count++;
        last_hs_cycle = cycle;
      end
      prev_stall = sample_valid && !sample_ready;
      prev_out = sample_out;
      prev_idx = sample_index;
      if (done) begin
        done_count++;
        done_cycle = cycle;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (reset) begin
      q.delete();
    end else begin
      if (cap_pop && q.size() > 0) void'(q.pop_front());
      if (cap_req) begin
        q.push_back('{adx: cap_adx, t: cycle + latency});
        issue_total++;
      end
    end
    has_return_data = (q.size() > 0) && (q[0].t <= cycle);
    return_adx  = (q.size() > 0) ? (q[0].adx ^ (corrupt ? 27'h1 : 27'h0)) : 27'h0;
    return_data = (q.size() > 0) ? word_val(q[0].adx) : 128'h0;
    read_allowed = (issue_total < allow_limit);
    sample_ready = ready_toggle ? ~sample_ready : 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input logic [26:0] base, input logic [31:0] count);
    step();
    run_base = base;
    base_adx = base;
    sample_count = count;
    hs_count = 0; n_issued = 0; n_popped = 0; max_inflight = 0;
    done_count = 0; done_cycle = -1; last_hs_cycle = -1;
    adx_log.delete();
    start_cycle = cycle;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_count == 0 && n < budget) begin
      step();
      n++;
    end
    check("done_seen", done_count > 0, 1'b1);
    step();
    step();
    check("done_single", done_count, 1);
    check("idle_after", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_adx = '0; sample_count = '0;
    read_allowed = 1'b1; has_return_data = 1'b0;
    return_data = '0; return_adx = '0; sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {read_req, get_return_data, sample_valid, busy, done, aborted, adx_error},
          7'b0);
    check("rst_index", sample_index, 0);
    check("rst_sample", sample_out, 0);
    check("rst_adx", rd_adx, 0);
    step();
    reset = 1'b0;

    // Basic 8-sample run with zero-latency returns.
    start_run(27'h0, 32'd8);
    wait_done(200);
    check("t1_reads", n_issued, 2);
    check("t1_samples", hs_count, 8);
    check("t1_done_lat", done_cycle, last_hs_cycle + 1);
    check("t1_adx_err", adx_error, 1'b0);
    check("t1_last_idx", sample_index, 7);

    // Partial last word.
    start_run(27'h40, 32'd5);
    wait_done(200);
    check("t2_reads", n_issued, 2);
    check("t2_samples", hs_count, 5);
    check("t2_last_idx", sample_index, 4);

    // Long latency exercises the outstanding-read limit.
    latency = 20;
    start_run(27'h0, 32'd64);
    wait_done(2000);
    check("t3_reads", n_issued, 16);
    check("t3_samples", hs_count, 64);
    check("t3_max_inflight", max_inflight, 4);
    check("t3_last_adx", adx_log[15], 27'd120);
    latency = 0;

    // Back-pressure on every other cycle.
    ready_toggle = 1'b1;
    start_run(27'h200, 32'd12);
    wait_done(400);
    check("t4_samples", hs_count, 12);
    check("t4_reads", n_issued, 3);
    ready_toggle = 1'b0;

    // Address wrap at the top of DRAM.
    start_run(27'h7FFFFF8, 32'd8);
    wait_done(200);
    check("t5_adx0", adx_log[0], 27'h7FFFFF8);
    check("t5_adx1", adx_log[1], 27'h0);
    check("t5_adx_err", adx_error, 1'b0);
    check("t5_samples", hs_count, 8);

    // Zero-length run.
    start_run(27'h0, 32'd0);
    wait_done(20);
    check("t6_reads", n_issued, 0);
    check("t6_done_lat", done_cycle, start_cycle + 1);

    // Return-address mismatch is flagged but data still flows.
    corrupt = 1'b1;
    start_run(27'h80, 32'd4);
    wait_done(200);
    corrupt = 1'b0;
    check("t7_adx_err", adx_error, 1'b1);
    check("t7_samples", hs_count, 4);

    // Abort with 3 reads issued and 1 returned.
    latency = 4;
    allow_limit = 3;
    issue_total = 0;
    start_run(27'h100, 32'd64);
    begin
      int n = 0;
      while (n_popped < 1 && n < 200) begin
        step();
        n++;
      end
    end
    check("t8_popped_first", n_popped, 1);
    check("t8_issued", n_issued, 3);
    abort = 1'b1;
    allow_limit = 1 << 30;
    read_allowed = 1'b1;
    @(negedge clk);
    check("t8_abort_rreq", read_req, 1'b0);
    check("t8_abort_valid", sample_valid, 1'b0);
    step();
    abort = 1'b0;
    wait_done(200);
    check("t8_popped_all", n_popped, 3);
    check("t8_no_more_reads", n_issued, 3);
    check("t8_aborted", aborted, 1'b1);
    latency = 0;

    // A fresh start clears the sticky abort flag.
    start_run(27'h0, 32'd4);
    check("t9_aborted_clr", aborted, 1'b0);
    check("t9_adx_err_clr", adx_error, 1'b0);
    wait_done(200);
    check("t9_samples", hs_count, 4);

    // Reset in the middle of a run.
    latency = 20;
    start_run(27'h0, 32'd64);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t10_busy", busy, 1'b0);
    check("t10_state_outs", {read_req, get_return_data, sample_valid, done}, 4'b0);
    check("t10_index", sample_index, 0);
    latency = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
